// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions: default sizes, bank state encoding and
// the bit-reversal helper used to place samples in bit-reversed order.
package fft_pkg;

    localparam int unsigned FFT_N         = 16;
    localparam int unsigned FFT_WIDTH     = 16;
    localparam int unsigned FFT_MAX_LOG2N = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Reverse the low log2n bits of idx: mirror all bits, then drop the unused tail.
    function automatic logic [FFT_MAX_LOG2N-1:0] bitrev(
        input logic [FFT_MAX_LOG2N-1:0] idx,
        input int unsigned              log2n
    );
        logic [FFT_MAX_LOG2N-1:0] r;
        for (int i = 0; i < int'(FFT_MAX_LOG2N); i++) begin
            r[i] = idx[FFT_MAX_LOG2N-1-i];
        end
        return r >> (FFT_MAX_LOG2N - log2n);
    endfunction

endpackage

// File: rtl/fft_bank.sv
// One N-entry complex sample bank: slot write port, flat read-out,
// per-frame ordering mode bit and the bank fill state.
module fft_bank
    import fft_pkg::*;
#(
    parameter int unsigned N     = FFT_N,
    parameter int unsigned LOG2N = 4,
    parameter int unsigned WIDTH = FFT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [LOG2N-1:0]     i_wr_slot,
    input  logic [WIDTH-1:0]     i_wr_re,
    input  logic [WIDTH-1:0]     i_wr_im,
    input  logic                 i_mode_en,
    input  logic                 i_mode,
    input  bank_state_e          i_state_d,
    output logic [N*WIDTH-1:0]   o_re_flat,
    output logic [N*WIDTH-1:0]   o_im_flat,
    output logic                 o_mode,
    output bank_state_e          o_state
);

    logic [WIDTH-1:0] r_re [N];
    logic [WIDTH-1:0] r_im [N];
    logic             r_mode;
    bank_state_e      r_state;

    // Sample storage is never reset; a bank is only meaningful once FULL.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_re[i_wr_slot] <= i_wr_re;
            r_im[i_wr_slot] <= i_wr_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= BANK_EMPTY;
            r_mode  <= 1'b0;
        end else begin
            r_state <= i_state_d;
            if (i_mode_en) begin
                r_mode <= i_mode;
            end
        end
    end

    for (genvar k = 0; k < int'(N); k++) begin : g_flat
        assign o_re_flat[k*WIDTH +: WIDTH] = r_re[k];
        assign o_im_flat[k*WIDTH +: WIDTH] = r_im[k];
    end

    assign o_mode  = r_mode;
    assign o_state = r_state;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding the FFT core: assembles N-sample frames from a
// serial stream (optionally bit-reversed) and hands them over as flat words.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int unsigned N     = FFT_N,
    parameter int unsigned LOG2N = 4,
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_re,
    input  logic [WIDTH-1:0]     s_im,
    input  logic                 s_last,
    input  logic                 bitrev_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N*WIDTH-1:0]   m_re_flat,
    output logic [N*WIDTH-1:0]   m_im_flat,
    output logic                 m_bitrev,
    output logic                 frame_err,
    output logic [CNTW-1:0]      drop_cnt
);

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [LOG2N-1:0] r_wr_idx;
    logic             r_frame_err;
    logic [CNTW-1:0]  r_drop_cnt;

    bank_state_e      w_state   [2];
    bank_state_e      w_state_d [2];
    logic             w_mode    [2];
    logic [N*WIDTH-1:0] w_re_flat [2];
    logic [N*WIDTH-1:0] w_im_flat [2];

    logic             w_accept;
    logic             w_consume;
    logic             w_first;
    logic             w_idx_last;
    logic             w_complete;
    logic             w_drop;
    logic             w_slot_mode;
    logic [LOG2N-1:0] w_slot;

    assign s_ready    = rst && (w_state[r_wr_bank] != BANK_FULL);
    assign m_valid    = (w_state[r_rd_bank] == BANK_FULL);
    assign w_accept   = s_valid && s_ready;
    assign w_consume  = m_valid && m_ready;
    assign w_first    = (r_wr_idx == '0);
    assign w_idx_last = (r_wr_idx == LOG2N'(N-1));
    assign w_complete = w_accept && w_idx_last && s_last;
    assign w_drop     = w_accept && (s_last != w_idx_last);

    // The first sample of a frame already follows the mode it is latching.
    assign w_slot_mode = w_first ? bitrev_en : w_mode[r_wr_bank];
    assign w_slot      = w_slot_mode ? LOG2N'(bitrev(FFT_MAX_LOG2N'(r_wr_idx), LOG2N))
                                     : r_wr_idx;

    // Consume and accept always target different banks, so both can apply.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_d[b] = w_state[b];
            if (w_consume && (r_rd_bank == 1'(b))) begin
                w_state_d[b] = BANK_EMPTY;
            end
            if (w_accept && (r_wr_bank == 1'(b))) begin
                if (w_complete) begin
                    w_state_d[b] = BANK_FULL;
                end else if (w_drop) begin
                    w_state_d[b] = BANK_EMPTY;
                end else begin
                    w_state_d[b] = BANK_FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_frame_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_frame_err <= w_drop;
            if (w_consume) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_accept) begin
                if (w_complete) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else if (w_drop) begin
                    r_wr_idx <= '0;
                    if (r_drop_cnt != '1) begin
                        r_drop_cnt <= r_drop_cnt + CNTW'(1);
                    end
                end else begin
                    r_wr_idx <= r_wr_idx + LOG2N'(1);
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bank #(
            .N     (N),
            .LOG2N (LOG2N),
            .WIDTH (WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_accept && (r_wr_bank == 1'(b))),
            .i_wr_slot (w_slot),
            .i_wr_re   (s_re),
            .i_wr_im   (s_im),
            .i_mode_en (w_accept && w_first && (r_wr_bank == 1'(b))),
            .i_mode    (bitrev_en),
            .i_state_d (w_state_d[b]),
            .o_re_flat (w_re_flat[b]),
            .o_im_flat (w_im_flat[b]),
            .o_mode    (w_mode[b]),
            .o_state   (w_state[b])
        );
    end

    assign m_re_flat = w_re_flat[r_rd_bank];
    assign m_im_flat = w_im_flat[r_rd_bank];
    assign m_bitrev  = w_mode[r_rd_bank];
    assign frame_err = r_frame_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: a 16-point/16-bit instance for the main
// scenarios and a 64-point/24-bit instance for the parametrised ordering checks.
module tb_fft_frame_buffer;

    localparam int unsigned W   = 16;
    localparam int unsigned NN  = 16;
    localparam int unsigned W64 = 24;
    localparam int unsigned N64 = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              s_valid = 1'b0, s_ready, s_last = 1'b0, bitrev_en = 1'b0;
    logic [W-1:0]      s_re = '0, s_im = '0;
    logic              m_valid, m_ready = 1'b0, m_bitrev, frame_err;
    logic [NN*W-1:0]   m_re_flat, m_im_flat;
    logic [15:0]       drop_cnt;

    logic              d_s_valid = 1'b0, d_s_ready, d_s_last = 1'b0, d_bitrev_en = 1'b0;
    logic [W64-1:0]    d_s_re = '0, d_s_im = '0;
    logic              d_m_valid, d_m_ready = 1'b0, d_m_bitrev, d_frame_err;
    logic [N64*W64-1:0] d_m_re_flat, d_m_im_flat;
    logic [15:0]       d_drop_cnt;

    fft_frame_buffer #(.N(NN), .LOG2N(4), .WIDTH(W), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re),
        .s_im(s_im), .s_last(s_last), .bitrev_en(bitrev_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_re_flat(m_re_flat), .m_im_flat(m_im_flat),
        .m_bitrev(m_bitrev), .frame_err(frame_err), .drop_cnt(drop_cnt)
    );

    fft_frame_buffer #(.N(N64), .LOG2N(6), .WIDTH(W64), .CNTW(16)) u_dut64 (
        .clk(clk), .rst(rst), .s_valid(d_s_valid), .s_ready(d_s_ready), .s_re(d_s_re),
        .s_im(d_s_im), .s_last(d_s_last), .bitrev_en(d_bitrev_en), .m_valid(d_m_valid),
        .m_ready(d_m_ready), .m_re_flat(d_m_re_flat), .m_im_flat(d_m_im_flat),
        .m_bitrev(d_m_bitrev), .frame_err(d_frame_err), .drop_cnt(d_drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic br;
        int   slot;
        int   re;
        int   im;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] slot_re(input int s);
        logic signed [W-1:0] v;
        v = m_re_flat[s*W +: W];
        return v;
    endfunction

    function automatic logic signed [63:0] slot_im(input int s);
        logic signed [W-1:0] v;
        v = m_im_flat[s*W +: W];
        return v;
    endfunction

    function automatic logic signed [63:0] slot64_re(input int s);
        logic signed [W64-1:0] v;
        v = d_m_re_flat[s*W64 +: W64];
        return v;
    endfunction

    function automatic logic signed [63:0] slot64_im(input int s);
        logic signed [W64-1:0] v;
        v = d_m_im_flat[s*W64 +: W64];
        return v;
    endfunction

    task automatic send_sample(input int re, input int im, input logic last, input logic br);
        int t;
        s_re      = W'(re);
        s_im      = W'(im);
        s_last    = last;
        bitrev_en = br;
        s_valid   = 1'b1;
        t = 0;
        while (!s_ready && t < 200) begin
            step();
            t++;
        end
        if (!s_ready) check("s_ready_wait_timeout", s_ready, 1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Mode is driven only on sample 0; later samples carry the opposite value.
    task automatic send_frame(input int base, input logic br);
        for (int k = 0; k < int'(NN); k++) begin
            send_sample(base + k, -k, k == int'(NN) - 1, (k == 0) ? br : ~br);
        end
    endtask

    task automatic consume();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic send64(input int base, input logic br);
        int t;
        for (int k = 0; k < int'(N64); k++) begin
            d_s_re      = W64'(base + k);
            d_s_im      = W64'(-k);
            d_s_last    = (k == int'(N64) - 1);
            d_bitrev_en = (k == 0) ? br : ~br;
            d_s_valid   = 1'b1;
            t = 0;
            while (!d_s_ready && t < 200) begin
                step();
                t++;
            end
            if (!d_s_ready) check("n64_s_ready_wait_timeout", d_s_ready, 1);
            step();
        end
        d_s_valid = 1'b0;
        d_s_last  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0,  5, 1005,  -5};
        vt[1] = '{1'b0,  0, 1000,   0};
        vt[2] = '{1'b0, 15, 1015, -15};
        vt[3] = '{1'b1,  8, 1001,  -1};
        vt[4] = '{1'b1,  1, 1008,  -8};
        vt[5] = '{1'b1, 15, 1015, -15};
        vt[6] = '{1'b1,  2, 1004,  -4};
        vt[7] = '{1'b1,  3, 1012, -12};

        // Reset state
        step();
        step();
        check("rst_s_ready",   s_ready,   0);
        check("rst_m_valid",   m_valid,   0);
        check("rst_m_bitrev",  m_bitrev,  0);
        check("rst_frame_err", frame_err, 0);
        check("rst_drop_cnt",  drop_cnt,  0);
        rst = 1'b1;
        #1;
        check("run_s_ready", s_ready, 1);

        // Table: one frame per vector, check the ordering and a slot, then consume
        for (int i = 0; i < 8; i++) begin
            send_frame(1000, vt[i].br);
            check("vec_m_valid",  m_valid,  1);
            check("vec_m_bitrev", m_bitrev, vt[i].br);
            check("vec_slot_re",  slot_re(vt[i].slot), vt[i].re);
            check("vec_slot_im",  slot_im(vt[i].slot), vt[i].im);
            consume();
            check("vec_consumed", m_valid, 0);
        end

        // Back-pressure: two full banks stall the producer
        send_frame(100, 1'b0);
        send_frame(200, 1'b0);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_m_valid",     m_valid, 1);
        check("bp_frame0_slot", slot_re(4), 104);
        consume();
        check("bp_s_ready_high", s_ready, 1);
        check("bp_m_valid_f1",   m_valid, 1);
        check("bp_frame1_slot0", slot_re(0), 200);
        send_frame(300, 1'b0);
        check("bp_still_f1", slot_re(15), 215);
        consume();
        check("bp_f2_valid",  m_valid, 1);
        check("bp_f2_slot0",  slot_re(0), 300);
        check("bp_f2_slot15", slot_re(15), 315);
        consume();
        check("bp_drained", m_valid, 0);

        // Framing error: early s_last
        for (int k = 0; k < 10; k++) send_sample(1000 + k, -k, k == 9, 1'b0);
        check("early_frame_err", frame_err, 1);
        check("early_drop_cnt",  drop_cnt,  1);
        check("early_no_valid",  m_valid,   0);
        step();
        check("early_err_pulse_end", frame_err, 0);
        send_frame(2000, 1'b0);
        check("clean_m_valid", m_valid, 1);
        check("clean_slot7_re", slot_re(7), 2007);
        check("clean_slot7_im", slot_im(7), -7);
        consume();

        // Framing error: missing s_last
        for (int k = 0; k < 16; k++) send_sample(1000 + k, -k, 1'b0, 1'b0);
        check("nolast_frame_err", frame_err, 1);
        check("nolast_drop_cnt",  drop_cnt,  2);
        check("nolast_no_valid",  m_valid,   0);
        step();

        // Consume A in the same cycle B's last sample lands
        send_frame(400, 1'b0);
        check("conc_a_slot", slot_re(3), 403);
        for (int k = 0; k < 15; k++) send_sample(500 + k, -k, 1'b0, 1'b0);
        m_ready = 1'b1;
        send_sample(515, -15, 1'b1, 1'b0);
        m_ready = 1'b0;
        check("conc_m_valid", m_valid, 1);
        check("conc_b_slot3", slot_re(3), 503);
        check("conc_b_slot15", slot_re(15), 515);
        check("conc_s_ready", s_ready, 1);
        consume();
        check("conc_drained", m_valid, 0);

        // Reset mid-frame with a full bit-reversed frame pending
        send_frame(600, 1'b1);
        check("rst2_pre_bitrev", m_bitrev, 1);
        for (int k = 0; k < 8; k++) send_sample(700 + k, -k, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check("rst2_s_ready",   s_ready,   0);
        check("rst2_m_valid",   m_valid,   0);
        check("rst2_m_bitrev",  m_bitrev,  0);
        check("rst2_frame_err", frame_err, 0);
        check("rst2_drop_cnt",  drop_cnt,  0);
        rst = 1'b1;
        #1;
        check("rst2_s_ready_back", s_ready, 1);
        send_frame(3000, 1'b0);
        check("rst2_fresh_valid",  m_valid, 1);
        check("rst2_fresh_slot9",  slot_re(9), 3009);
        check("rst2_fresh_slot0",  slot_re(0), 3000);
        check("rst2_fresh_bitrev", m_bitrev, 0);
        consume();

        // 64-point / 24-bit instance
        send64(100000, 1'b1);
        check("n64_m_valid",   d_m_valid,  1);
        check("n64_m_bitrev",  d_m_bitrev, 1);
        check("n64_slot32_re", slot64_re(32), 100001);
        check("n64_slot32_im", slot64_im(32), -1);
        check("n64_slot1_re",  slot64_re(1),  100032);
        check("n64_slot6_re",  slot64_re(6),  100024);
        check("n64_slot63_re", slot64_re(63), 100063);
        d_m_ready = 1'b1;
        step();
        d_m_ready = 1'b0;
        check("n64_consumed", d_m_valid, 0);
        send64(200000, 1'b0);
        check("n64_nat_valid",   d_m_valid, 1);
        check("n64_nat_bitrev",  d_m_bitrev, 0);
        check("n64_nat_slot32",  slot64_re(32), 200032);
        check("n64_nat_slot5im", slot64_im(5), -5);
        check("n64_no_err",      d_frame_err, 0);
        check("n64_drop_cnt",    d_drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Parametrised ping-pong input frame buffer in front of the FFT core; successor to the fixed 16-point load/addr_in loading scheme.
- Accepts a serial complex sample stream through a valid/ready handshake.
- Assembles N-sample frames, optionally in bit-reversed order, and presents each complete frame flat to the FFT core through a second valid/ready handshake.
- Two banks allow frame k+1 to fill while the core consumes frame k.

Parameters:
- N, 16, FFT points per frame; power of two, 4..1024.
- LOG2N, 4, log2(N); must match N.
- WIDTH, 16, signed bits per real and per imaginary sample.
- CNTW, 16, width of the dropped-frame counter.

Ports:
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, synchronous, active-low reset.
- s_valid, in, 1, input sample valid.
- s_ready, out, 1, buffer can accept a sample.
- s_re, in, WIDTH, signed real sample.
- s_im, in, WIDTH, signed imaginary sample.
- s_last, in, 1, marks the final sample of a frame.
- bitrev_en, in, 1, ordering mode; sampled with the first sample of each frame.
- m_valid, out, 1, complete frame available.
- m_ready, in, 1, FFT core consumes the frame.
- m_re_flat, out, N*WIDTH, frame real parts; slot k at [k*WIDTH +: WIDTH].
- m_im_flat, out, N*WIDTH, frame imaginary parts; same packing.
- m_bitrev, out, 1, ordering mode of the presented frame.
- frame_err, out, 1, one-cycle pulse when a frame is dropped.
- drop_cnt, out, CNTW, saturating count of dropped frames.

Behaviour:
- Reset while rst=0 at a clock edge:
  - both banks EMPTY; wr_bank=0, rd_bank=0, wr_idx=0.
  - outputs: s_ready=0, m_valid=0, m_bitrev=0, frame_err=0, drop_cnt=0.
  - bank contents are not cleared.
  - Reset asserted mid-frame discards the partial frame and any full frames.
- Per-bank state: EMPTY -> FILLING (first sample accepted) -> FULL (valid last sample) -> EMPTY (consumed or dropped).
- s_ready = rst deasserted and bank[wr_bank] is not FULL. No combinational path from m_ready to s_ready; s_ready is a function of registered state only.
- Sample accept condition: s_valid && s_ready.
  - Write slot = bitrev_en_latched ? bitrev(wr_idx) : wr_idx.
  - wr_idx increments by 1.
  - On accept with wr_idx==0: latch bitrev_en into the bank mode bit; this first sample uses the new value.
- Frame completion: accept with wr_idx==N-1 and s_last=1.
  - Bank goes FULL; wr_bank toggles; wr_idx=0.
- Framing error: accept with s_last=1 and wr_idx<N-1, OR wr_idx==N-1 with s_last=0.
  - Bank returns to EMPTY; wr_idx=0; wr_bank unchanged.
  - frame_err pulses the next cycle.
  - drop_cnt increments, saturating at 2^CNTW-1.
- Output side:
  - m_valid = bank[rd_bank] FULL.
  - m_re_flat, m_im_flat and m_bitrev come from bank[rd_bank] and are stable while m_valid=1 and m_ready=0.
  - Consume (m_valid && m_ready): bank[rd_bank] goes EMPTY and rd_bank toggles.
- Latency: last sample accepted at edge t. m_valid rises after edge t if that bank is rd_bank; otherwise it rises after the edge that consumes the other bank.
- Both banks FULL: s_ready=0. Upstream stalls; no samples are lost.
- Simultaneous consume and last-sample accept in the same cycle are both honoured. The next cycle shows the other bank's state.
- m_ready with m_valid=0 is ignored.
- Data passes through unmodified; no scaling or sign extension.
- Throughput: one sample per cycle sustained when the core consumes within N cycles.

Decomposition:
- Shared package fft_pkg holds:
  - function bitrev(idx, LOG2N).
  - bank state encoding: BANK_EMPTY, BANK_FILLING, BANK_FULL.
  - default constants FFT_N=16, FFT_WIDTH=16.
- One sub-module, fft_bank: N-entry complex register bank with write port (en, slot, re, im), flat read-out, mode bit and state register.
- fft_frame_buffer instantiates two fft_bank instances plus the write/read control.

Test Plan:
- Reset then stream: samples k=0..15, re=1000+k, im=-k, bitrev_en=0, s_last on k=15, m_ready=0 -> m_valid=1 one cycle after the last accept; slot 5 holds re=1005, im=-5; m_bitrev=0.
- Bit-reverse mode: same stream with bitrev_en=1 on k=0 -> slot 8 holds re=1001, slot 1 holds re=1008, slot 15 holds re=1015; m_bitrev=1.
- Back-pressure: send 3 frames with m_ready=0 -> s_ready falls after the 32nd accept; release m_ready for 1 cycle -> frame 0 leaves, s_ready=1, frame 1 presented; no sample lost.
- Framing errors:
  - s_last on k=9 -> frame_err pulse, drop_cnt=1, no m_valid.
  - Next clean 16-sample frame -> delivered intact.
  - Missing s_last at k=15 -> drop_cnt=2.
- Concurrency and reset: consume frame A in the same cycle frame B's last sample is accepted -> m_valid stays 1, B presented next cycle. rst=0 mid-frame at k=7 -> all outputs at reset values next cycle; fresh frame delivered correctly.
- Parametrisation: N=64, WIDTH=24 -> the full-frame stream and bit-reverse checks pass; slot 32 equals sample 1 in bitrev mode.
